// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its input/result sequencer:
// operand/opcode/result widths, opcode encodings, the sequencer state
// encoding and the legal-opcode check used when ALU_SEQ_OPCHK_EN is defined.
package alu_pkg;

    localparam int ALU_OPND_W = 7;
    localparam int ALU_OP_W   = 6;
    localparam int ALU_RES_W  = 8;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [ALU_OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [ALU_OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [ALU_OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HOLD    = 3'd4
    } seq_state_e;

    // True when the opcode is one the ALU implements.
    function automatic logic alu_op_is_legal(input logic [ALU_OP_W-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences the combinational ALU: collects operand A, operand B and the
// opcode over a valid/ready stream, holds them on registered ALU inputs for
// SETTLE_CYCLES cycles, captures the result and offers it on a valid/ready
// result stream. No new operands are accepted while a result is pending.
// Optional feature macro: ALU_SEQ_OPCHK_EN -- when defined, illegal opcodes
// bypass the settle wait and return res_data = 0 with res_err = 1.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ALU_OPND_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ALU_OPND_W-1:0] alu_dataA,
    output logic [ALU_OPND_W-1:0] alu_dataB,
    output logic [ALU_OP_W-1:0]   alu_operation,
    input  logic [ALU_RES_W-1:0]  alu_result,
    output logic [ALU_RES_W-1:0]  res_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_err,
    output logic                 busy
);

    // Settle counter reload; the counter reaching zero marks the sample cycle.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seq_state_e            state_q;
    logic [3:0]            cnt_q;
    logic [ALU_OPND_W-1:0] dataA_q;
    logic [ALU_OPND_W-1:0] dataB_q;
    logic [ALU_OP_W-1:0]   op_q;
    logic [ALU_RES_W-1:0]  res_data_q;
    logic                  res_valid_q;
    logic                  busy_q;

`ifdef ALU_SEQ_OPCHK_EN
    logic                  res_err_q;
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // The input stream is open only while an operand set is being collected.
    assign in_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B) ||
                      (state_q == ST_LOAD_OP);

    assign alu_dataA     = dataA_q;
    assign alu_dataB     = dataB_q;
    assign alu_operation = op_q;
    assign res_data      = res_data_q;
    assign res_valid     = res_valid_q;
    assign busy          = busy_q;

    // Sequencer FSM with all outputs registered; reset discards any partial set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD_A;
            cnt_q       <= '0;
            dataA_q     <= '0;
            dataB_q     <= '0;
            op_q        <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ALU_SEQ_OPCHK_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (in_valid) begin
                        dataA_q <= in_data;
                        state_q <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (in_valid) begin
                        dataB_q <= in_data;
                        state_q <= ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (in_valid) begin
                        op_q   <= in_data[ALU_OP_W-1:0];
                        busy_q <= 1'b1;
`ifdef ALU_SEQ_OPCHK_EN
                        if (!alu_op_is_legal(in_data[ALU_OP_W-1:0])) begin
                            // Result is known without the ALU; valid follows one cycle later.
                            res_data_q <= '0;
                            res_err_q  <= 1'b1;
                            state_q    <= ST_HOLD;
                        end else begin
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= ST_EXEC;
                        end
`else
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= ST_EXEC;
`endif
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        res_data_q  <= alu_result;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (res_valid_q && res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_LOAD_A;
`ifdef ALU_SEQ_OPCHK_EN
                        res_err_q   <= 1'b0;
`endif
                    end else if (!res_valid_q) begin
                        // Only reached on the illegal-opcode bypass path.
                        res_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that sequences the combinational ALU (7-bit operands A/B, 6-bit opcode, 8-bit result). It accepts three 7-bit words over a valid/ready input stream: operand A, then operand B, then the opcode. It drives the ALU with registered operands, waits a programmable settle time, then captures the result and offers it on a valid/ready output stream. It sits between the board-level input front end (switch/UART loader) and the result display/transmit path.

## Interface
- `SETTLE_CYCLES`, 1: cycles the ALU inputs are held before the result is sampled; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  7  word being offered: A, B, or opcode in bits [5:0].
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  sequencer accepts a word this cycle.
- `alu_dataA`  out  7  registered operand A to the ALU.
- `alu_dataB`  out  7  registered operand B to the ALU.
- `alu_operation`  out  6  registered opcode to the ALU.
- `alu_result`  in  8  ALU combinational result.
- `res_data`  out  8  captured result.
- `res_valid`  out  1  `res_data`/`res_err` valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_err`  out  1  illegal-opcode flag (see Configuration).
- `busy`  out  1  high in EXEC and HOLD.

## Operation
- States: LOAD_A, LOAD_B, LOAD_OP, EXEC, HOLD. The reset state is LOAD_A.
- `in_ready` = 1 in the LOAD_* states and 0 otherwise. It is decoded from the state.
- A transfer occurs on an edge where `in_valid && in_ready`.
- LOAD_A: transfer writes `alu_dataA <= in_data`, then go to LOAD_B.
- LOAD_B: transfer writes `alu_dataB`, then go to LOAD_OP.
- LOAD_OP: transfer writes `alu_operation <= in_data[5:0]` (bit 6 ignored). Load the settle counter with `SETTLE_CYCLES-1`, then go to EXEC.
- EXEC: decrement the counter each cycle. When the counter is 0, capture `res_data <= alu_result`, set `res_valid`, and go to HOLD.
- HOLD: when `res_valid && res_ready`, clear `res_valid` and go to LOAD_A. Otherwise hold `res_data` and `res_err` stable.
- `alu_dataA`, `alu_dataB` and `alu_operation` keep their values until overwritten by the next transfer. The ALU output is therefore stable through EXEC and HOLD.
- No overlap: no input word is accepted while a result is pending.
- Reset values: `alu_dataA`, `alu_dataB`, `alu_operation`, `res_data` = 0; `res_valid`, `res_err`, `busy` = 0. `in_ready` = 1, since the reset state is LOAD_A.
- Reset asserted mid-sequence aborts the sequence. All registers return to their reset values and any partial operand set is discarded.

## Timing
- Earliest sequence: A at edge k, B at k+1, opcode at k+2.
- `res_valid` rises after edge k+2+`SETTLE_CYCLES`.
- With `res_ready` held high, `res_valid` is high for exactly one cycle. The next A is accepted at the following edge at the earliest, which is one LOAD_A cycle later.
- Gaps in `in_valid` stretch the LOAD_* states indefinitely without side effects.
- `res_ready` asserted before `res_valid` has no effect.

## Configuration
- `ALU_SEQ_OPCHK_EN` defined:
  - In LOAD_OP, the accepted opcode is checked against the legal set: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
  - An illegal opcode skips EXEC and goes directly to HOLD, with `res_data` = 8'h00 and `res_err` = 1.
  - `res_valid` rises after edge k+3.
  - `res_err` clears on the result handshake.
- `ALU_SEQ_OPCHK_EN` undefined:
  - Every opcode passes through EXEC.
  - `res_err` is tied 0.

## Structure
- Shared package `alu_pkg` holds:
  - width constants: `ALU_OPND_W` = 7, `ALU_OP_W` = 6, `ALU_RES_W` = 8;
  - opcode localparams (`OP_ADD` … `OP_SRL`);
  - the sequencer state encoding.
- Single module, no sub-module.
- The legal-opcode check is a package function used under `ALU_SEQ_OPCHK_EN`.

## Test plan
- Reset, then A=7'b0000111, B=7'b0000010, op=6'b000010 (SRL), `res_ready`=1 → `res_data`=8'h01, `res_err`=0, `res_valid` one cycle, back to LOAD_A.
- Same operands, op=ADD 100000, `SETTLE_CYCLES`=3 → `res_valid` rises exactly 3 cycles after the opcode edge, `res_data`=8'h09.
- ADD 7'h7F+7'h7F with `res_ready` low for 5 cycles → `res_data`=8'hFE held stable, `in_ready`=0, `busy`=1 throughout. The handshake on cycle 6 returns to LOAD_A.
- `in_valid` toggled every other cycle while loading AND 7'h0F,7'h3C → words taken only on valid edges, `res_data`=8'h0C.
- Opcode 6'b111111:
  - with `ALU_SEQ_OPCHK_EN` → `res_err`=1, `res_data`=8'h00, `res_valid` after one cycle;
  - without → `res_err`=0, `res_data` equals `alu_result`.
- `rst_n` pulsed low after B accepted → all outputs at reset values, `in_ready`=1. A new full sequence then completes correctly.
